// File: rtl/vx_csr_warp_tracker.sv
// vx_csr_warp_tracker
//
// Scheduler-side tracker for the scheduler-to-CSR interface. It keeps a
// per-warp count of in-flight instructions, holds per-warp issue locks for
// FPU-CSR fencing, and provides the free-running cycle counter.
//
// Event semantics: every *_fire / *_valid / unlock_warp input is a
// single-cycle pulse qualified only by itself. There is no back-pressure
// on any of them. The pulse takes effect at the next rising clk edge, and
// its result is visible in the registered state from the following cycle.
//
// Ports
//   clk, reset     : clock and synchronous active-high reset
//   issue_fire/wid : an instruction was issued to warp issue_wid
//   commit_fire/wid: an instruction of warp commit_wid committed
//   lock_valid/wid : decode saw an FPU-CSR access; lock that warp
//   unlock_warp/wid: the CSR unit releases the lock of unlock_wid
//   alm_empty_wid  : warp queried by the CSR unit
//   alm_empty      : queried warp has <= 1 instruction in flight
//   stall_mask     : per-warp issue inhibit (locked or full)
//   pending_cnt    : packed per-warp in-flight counts, warp w at [w*CNTW +: CNTW]
//   cycles         : 64-bit free-running cycle count
module vx_csr_warp_tracker #(
    parameter int NUM_WARPS   = 4,
    parameter int MAX_PENDING = 15,
    parameter int CNTW        = $clog2(MAX_PENDING + 1),
    parameter int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      issue_fire,
    input  logic [NW_WIDTH-1:0]       issue_wid,
    input  logic                      commit_fire,
    input  logic [NW_WIDTH-1:0]       commit_wid,
    input  logic                      lock_valid,
    input  logic [NW_WIDTH-1:0]       lock_wid,
    input  logic                      unlock_warp,
    input  logic [NW_WIDTH-1:0]       unlock_wid,
    input  logic [NW_WIDTH-1:0]       alm_empty_wid,
    output logic                      alm_empty,
    output logic [NUM_WARPS-1:0]      stall_mask,
    output logic [NUM_WARPS*CNTW-1:0] pending_cnt,
    output logic [63:0]               cycles
);

    logic [CNTW-1:0]      cnt [NUM_WARPS];
    logic [NUM_WARPS-1:0] locked;
    logic [NUM_WARPS-1:0] inc;
    logic [NUM_WARPS-1:0] dec;
    logic [NUM_WARPS-1:0] lock_set;
    logic [NUM_WARPS-1:0] lock_clr;
    logic [NUM_WARPS-1:0] full;
    logic [NUM_WARPS-1:0] empty;

    // Per-warp event decode. Out-of-range wids match no warp and are
    // therefore ignored.
    always_comb begin
        inc      = '0;
        dec      = '0;
        lock_set = '0;
        lock_clr = '0;
        full     = '0;
        empty    = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            inc[w]      = issue_fire  && (issue_wid  == NW_WIDTH'(w));
            dec[w]      = commit_fire && (commit_wid == NW_WIDTH'(w));
            lock_set[w] = lock_valid  && (lock_wid   == NW_WIDTH'(w));
            lock_clr[w] = unlock_warp && (unlock_wid == NW_WIDTH'(w));
            full[w]     = (cnt[w] == CNTW'(MAX_PENDING));
            empty[w]    = (cnt[w] == '0);
        end
    end

    // In-flight counters. Simultaneous inc and dec cancel. Overflow and
    // underflow are protocol violations; the counter saturates instead of
    // wrapping so the stall mask stays meaningful.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                cnt[w] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (inc[w] && !dec[w] && !full[w]) begin
                    cnt[w] <= cnt[w] + CNTW'(1);
                end else if (dec[w] && !inc[w] && !empty[w]) begin
                    cnt[w] <= cnt[w] - CNTW'(1);
                end
            end
        end
    end

    // Issue locks. A lock and an unlock of the same warp in one cycle
    // leave the warp locked, because the locking instruction is newer.
    always_ff @(posedge clk) begin
        if (reset) begin
            locked <= '0;
        end else begin
            locked <= (locked & ~lock_clr) | lock_set;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycles <= '0;
        end else begin
            cycles <= cycles + 64'd1;
        end
    end

    // Derived only from registered state, so there is no combinational
    // path from issue_fire to stall_mask.
    assign stall_mask = locked | full;

    // The count includes the querying CSR instruction itself. A commit in
    // the same cycle is not forwarded, so the answer may lag by one cycle.
    // This is safe because the error is always toward "not empty".
    always_comb begin
        alm_empty = 1'b1;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (alm_empty_wid == NW_WIDTH'(w)) begin
                alm_empty = (cnt[w] <= CNTW'(1));
            end
        end
    end

    always_comb begin
        pending_cnt = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            pending_cnt[w*CNTW +: CNTW] = cnt[w];
        end
    end

    // Protocol checks on upstream behaviour.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                assert (!(inc[w] && !dec[w] && full[w]))
                    else $error("vx_csr_warp_tracker: issue to full warp %0d", w);
                assert (!(dec[w] && !inc[w] && empty[w]))
                    else $error("vx_csr_warp_tracker: commit on empty warp %0d", w);
            end
        end
    end

endmodule
